// File: rtl/pipeline_interlock.sv
// pipeline_interlock: load-use / cold-store stall and taken-branch flush control for the 5-stage core
module pipeline_interlock #(
    parameter int FLUSH_CYCLES  = 1,
    parameter bit SW_COLD_STALL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] id_instr,
    input  logic        id_valid,
    input  logic        br_taken,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_bubble,
    output logic        flush,
    output logic [1:0]  hazard_cause,
    output logic [15:0] stall_cnt
);
    typedef enum logic {RUN, FLUSH} state_t;
    state_t      state_q, state_d;
    logic [1:0]  flush_ctr_q, flush_ctr_d;
    logic        ex_vld_q, ex_vld_d, ex_ld_q, ex_ld_d, ma_vld_q, ma_vld_d;
    logic [2:0]  ex_dst_q, ex_dst_d, ma_dst_q, ma_dst_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [3:0]  op;
    logic [2:0]  rs, rt, rd, dst;
    logic        use_rs, use_rt, dst_vld, ex_hit, ma_hit, load_use, sw_cold;
    logic        in_flush, brk, stall, bubble, unused_fn;
    assign unused_fn = ^id_instr[2:0];
    always_comb begin
        op       = id_instr[15:12];
        rs       = id_instr[11:9];
        rt       = id_instr[8:6];
        rd       = id_instr[5:3];
        use_rs   = id_valid & (op == 4'd0 | op == 4'd1 | op == 4'd3 | op == 4'd4 | op == 4'd5 | op == 4'd6);
        use_rt   = id_valid & (op == 4'd0 | op == 4'd5 | op == 4'd6);
        dst      = (op == 4'd0) ? rd : rt;
        // r0 never becomes a tracked destination, so it can never match a source
        dst_vld  = id_valid & (op == 4'd0 | op == 4'd1 | op == 4'd3 | op == 4'd4) & (dst != 3'd0);
        ex_hit   = ex_vld_q & ((use_rs & rs == ex_dst_q) | (use_rt & rt == ex_dst_q));
        ma_hit   = ma_vld_q & ((use_rs & rs == ma_dst_q) | (use_rt & rt == ma_dst_q));
        load_use = ex_hit & ex_ld_q;
        sw_cold  = SW_COLD_STALL & id_valid & (op == 4'd5) & ma_hit & ~ex_hit;
        in_flush = (state_q == FLUSH);
        brk      = ~in_flush & br_taken;
        stall    = ~in_flush & ~br_taken & (load_use | sw_cold);
        bubble   = rst | in_flush | brk | stall;
        pc_en        = ~rst & ~stall;
        ifid_en      = ~rst & ~stall;
        idex_bubble  = bubble;
        flush        = ~rst & brk;
        hazard_cause = rst ? 2'b00 : (in_flush | brk) ? 2'b11 : stall ? (load_use ? 2'b01 : 2'b10) : 2'b00;
        stall_cnt    = stall_cnt_q;
        ex_vld_d    = ~bubble & dst_vld;
        ex_ld_d     = ~bubble & dst_vld & (op == 4'd4);
        ex_dst_d    = dst;
        ma_vld_d    = ex_vld_q;
        ma_dst_d    = ex_dst_q;
        state_d     = in_flush ? ((flush_ctr_q == 2'd1) ? RUN : FLUSH) : ((brk && FLUSH_CYCLES > 1) ? FLUSH : RUN);
        flush_ctr_d = in_flush ? flush_ctr_q - 2'd1 : ((brk && FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 1) : 2'd0);
        stall_cnt_d = (stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            flush_ctr_q <= 2'd0;
            ex_vld_q    <= 1'b0;
            ex_ld_q     <= 1'b0;
            ex_dst_q    <= 3'd0;
            ma_vld_q    <= 1'b0;
            ma_dst_q    <= 3'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            flush_ctr_q <= flush_ctr_d;
            ex_vld_q    <= ex_vld_d;
            ex_ld_q     <= ex_ld_d;
            ex_dst_q    <= ex_dst_d;
            ma_vld_q    <= ma_vld_d;
            ma_dst_q    <= ma_dst_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_pipeline_interlock.sv
// tb_pipeline_interlock: directed vectors against two interlock configurations
module tb_pipeline_interlock;
    logic        clk = 1'b0, rst = 1'b1, id_valid = 1'b0, br_taken = 1'b0;
    logic [15:0] id_instr = 16'hF000;
    logic        pc_en, ifid_en, idex_bubble, flush;
    logic [1:0]  hazard_cause;
    logic [15:0] stall_cnt;
    logic        pc_en0, ifid_en0, idex_bubble0, flush0;
    logic [1:0]  hazard_cause0;
    logic [15:0] stall_cnt0;
    int          total = 0, bad = 0;
    always #5 clk = ~clk;
    pipeline_interlock #(.FLUSH_CYCLES(2), .SW_COLD_STALL(1'b1)) dut (
        .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid), .br_taken(br_taken),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_bubble(idex_bubble), .flush(flush),
        .hazard_cause(hazard_cause), .stall_cnt(stall_cnt));
    pipeline_interlock #(.FLUSH_CYCLES(1), .SW_COLD_STALL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid), .br_taken(br_taken),
        .pc_en(pc_en0), .ifid_en(ifid_en0), .idex_bubble(idex_bubble0), .flush(flush0),
        .hazard_cause(hazard_cause0), .stall_cnt(stall_cnt0));
    function automatic logic [15:0] r_add(input logic [2:0] d, input logic [2:0] s, input logic [2:0] t);
        return {4'd0, s, t, d, 3'b000};
    endfunction
    function automatic logic [15:0] i_op(input logic [3:0] o, input logic [2:0] t, input logic [2:0] s);
        return {o, s, t, 6'd0};
    endfunction
    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic drive(input logic r, input logic [15:0] i, input logic v, input logic b);
        @(negedge clk);
        rst = r; id_instr = i; id_valid = v; br_taken = b;
        #1;
    endtask
    task automatic expo(input string tag, input logic pc, input logic bub, input logic fl, input logic [1:0] c);
        chk({tag, ".pc_en"}, 16'(pc_en), 16'(pc));
        chk({tag, ".ifid_en"}, 16'(ifid_en), 16'(pc));
        chk({tag, ".bubble"}, 16'(idex_bubble), 16'(bub));
        chk({tag, ".flush"}, 16'(flush), 16'(fl));
        chk({tag, ".cause"}, 16'(hazard_cause), 16'(c));
    endtask
    initial begin
        drive(1'b1, 16'hF000, 1'b0, 1'b0);
        expo("rst", 1'b0, 1'b1, 1'b0, 2'b00);
        drive(1'b1, 16'hF000, 1'b1, 1'b1);
        expo("rst_br", 1'b0, 1'b1, 1'b0, 2'b00);
        chk("rst.cnt", stall_cnt, 16'd0);
        // load-use: lw r2,0(r1) ; add r3,r2,r1
        drive(1'b0, i_op(4'd4, 3'd2, 3'd1), 1'b1, 1'b0);
        expo("lu.lw", 1'b1, 1'b0, 1'b0, 2'b00);
        drive(1'b0, r_add(3'd3, 3'd2, 3'd1), 1'b1, 1'b0);
        expo("lu.stall", 1'b0, 1'b1, 1'b0, 2'b01);
        chk("lu.cnt0", stall_cnt, 16'd0);
        drive(1'b0, r_add(3'd3, 3'd2, 3'd1), 1'b1, 1'b0);
        expo("lu.go", 1'b1, 1'b0, 1'b0, 2'b00);
        chk("lu.cnt1", stall_cnt, 16'd1);
        // distance 2 and lw r0
        drive(1'b0, i_op(4'd4, 3'd2, 3'd1), 1'b1, 1'b0);
        drive(1'b0, r_add(3'd4, 3'd5, 3'd6), 1'b1, 1'b0);
        expo("d2.mid", 1'b1, 1'b0, 1'b0, 2'b00);
        drive(1'b0, r_add(3'd3, 3'd2, 3'd1), 1'b1, 1'b0);
        expo("d2.use", 1'b1, 1'b0, 1'b0, 2'b00);
        drive(1'b0, i_op(4'd4, 3'd0, 3'd1), 1'b1, 1'b0);
        drive(1'b0, r_add(3'd3, 3'd0, 3'd1), 1'b1, 1'b0);
        expo("r0.use", 1'b1, 1'b0, 1'b0, 2'b00);
        // cold store: add r2,r1,r1 ; addi r7,r7,1 ; sw rs=r1 rt=r2
        drive(1'b0, r_add(3'd2, 3'd1, 3'd1), 1'b1, 1'b0);
        drive(1'b0, i_op(4'd1, 3'd7, 3'd7), 1'b1, 1'b0);
        drive(1'b0, i_op(4'd5, 3'd2, 3'd1), 1'b1, 1'b0);
        expo("sw.cold", 1'b0, 1'b1, 1'b0, 2'b10);
        chk("sw0.pc_en", 16'(pc_en0), 16'd1);
        chk("sw0.cause", 16'(hazard_cause0), 16'd0);
        drive(1'b0, i_op(4'd5, 3'd2, 3'd1), 1'b1, 1'b0);
        expo("sw.go", 1'b1, 1'b0, 1'b0, 2'b00);
        chk("sw.cnt", stall_cnt, 16'd2);
        chk("sw0.cnt", stall_cnt0, 16'd1);
        // store at distance 1 behind an ALU producer is forwarded
        drive(1'b0, r_add(3'd2, 3'd1, 3'd1), 1'b1, 1'b0);
        drive(1'b0, i_op(4'd5, 3'd2, 3'd1), 1'b1, 1'b0);
        expo("sw.d1", 1'b1, 1'b0, 1'b0, 2'b00);
        // branch beats load-use
        drive(1'b0, i_op(4'd4, 3'd2, 3'd1), 1'b1, 1'b0);
        drive(1'b0, r_add(3'd3, 3'd2, 3'd1), 1'b1, 1'b1);
        expo("br.c0", 1'b1, 1'b1, 1'b1, 2'b11);
        drive(1'b0, r_add(3'd3, 3'd2, 3'd1), 1'b1, 1'b1);
        expo("br.c1", 1'b1, 1'b1, 1'b0, 2'b11);
        chk("br0.flush", 16'(flush0), 16'd1);
        drive(1'b0, r_add(3'd3, 3'd2, 3'd1), 1'b1, 1'b0);
        expo("br.run", 1'b1, 1'b0, 1'b0, 2'b00);
        chk("br0.cause", 16'(hazard_cause0), 16'd0);
        chk("br.cnt", stall_cnt, 16'd2);
        // reset in the middle of a stall
        drive(1'b0, i_op(4'd4, 3'd2, 3'd1), 1'b1, 1'b0);
        drive(1'b0, r_add(3'd3, 3'd2, 3'd1), 1'b1, 1'b0);
        expo("rs.stall", 1'b0, 1'b1, 1'b0, 2'b01);
        drive(1'b1, r_add(3'd3, 3'd2, 3'd1), 1'b1, 1'b0);
        expo("rs.in", 1'b0, 1'b1, 1'b0, 2'b00);
        drive(1'b0, r_add(3'd3, 3'd2, 3'd1), 1'b1, 1'b0);
        expo("rs.after", 1'b1, 1'b0, 1'b0, 2'b00);
        chk("rs.cnt", stall_cnt, 16'd0);
        // saturation: preload the counter near the top, then stall repeatedly
        @(negedge clk);
        force dut.stall_cnt_q = 16'hFFFD;
        drive(1'b0, 16'hF000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        release dut.stall_cnt_q;
        chk("sat.pre", stall_cnt, 16'hFFFD);
        for (int k = 1; k <= 3; k++) begin
            drive(1'b0, i_op(4'd4, 3'd2, 3'd1), 1'b1, 1'b0);
            drive(1'b0, r_add(3'd3, 3'd2, 3'd1), 1'b1, 1'b0);
            chk("sat.stall", 16'(pc_en), 16'd0);
            drive(1'b0, r_add(3'd3, 3'd2, 3'd1), 1'b1, 1'b0);
            chk("sat.cnt", stall_cnt, (k == 1) ? 16'hFFFE : 16'hFFFF);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
